amp_cfg_sched: RTL



---
 rtl/amp_cfg_pkg.sv | 31 +++
 rtl/amp_cfg_sched_if.sv | 20 ++
 rtl/amp_cfg_rr_arb.sv | 29 ++
 rtl/amp_cfg_sched.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/amp_cfg_pkg.sv
// Shared types and constants for the amp I2C write scheduler.
// Holds field widths, the default page-select register address, the
// scheduler state encoding and the latched write-request payload.
package amp_cfg_pkg;

  localparam int unsigned PAGE_W  = 6;
  localparam int unsigned REG_W   = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TMO_W   = 12;
  localparam int unsigned RETRY_W = 3;

  localparam logic [REG_W-1:0] PAGE_REG_DEF = 7'h00;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TAKE     = 3'd1,
    ST_PG_ISSUE = 3'd2,
    ST_PG_WAIT  = 3'd3,
    ST_DT_ISSUE = 3'd4,
    ST_DT_WAIT  = 3'd5,
    ST_RESP     = 3'd6,
    ST_ABORT    = 3'd7
  } state_e;

  typedef struct packed {
    logic [PAGE_W-1:0] page;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/amp_cfg_sched_if.sv
// Scheduler <-> I2C write engine handshake.
//   eng_start : 1-cycle pulse, engine begins a write of eng_reg/eng_data
//   eng_busy  : engine transaction in progress
//   eng_done  : 1-cycle pulse, transaction finished (eng_nack qualifies it)
// master = scheduler side, slave = engine side.
interface amp_cfg_sched_if;
  import amp_cfg_pkg::*;

  logic              eng_start;
  logic [REG_W-1:0]  eng_reg;
  logic [DATA_W-1:0] eng_data;
  logic              eng_busy;
  logic              eng_done;
  logic              eng_nack;

  modport master (output eng_start, eng_reg, eng_data,
                  input  eng_busy, eng_done, eng_nack);
  modport slave  (input  eng_start, eng_reg, eng_data,
                  output eng_busy, eng_done, eng_nack);
endinterface

// File: rtl/amp_cfg_rr_arb.sv
// Two-way round-robin picker.
//   req[1:0]  : candidate requests
//   advance   : a service finished this cycle; remember who was served
//   served    : id of the requester just served
//   gnt_c     : one-hot winner (combinational), 0 when no request
// After reset the pointer favours requester 0.
module amp_cfg_rr_arb (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic [1:0] gnt_c
);

  logic last_q;

  // last_q = id served most recently; reset to 1 so req0 wins the first tie
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)        last_q <= 1'b1;
    else if (advance) last_q <= served;
  end

  always_comb begin
    gnt_c = req;
    if (req == 2'b11) gnt_c = last_q ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/amp_cfg_sched.sv
// Arbitrates two requesters onto the amp I2C single-byte write engine,
// inserts page-select writes, retries NACKs and aborts on timeout.
// Ports:
//   clk_in, reset          : clock, async active-high reset
//   reqN/pageN/regN/dataN  : requester N write request (held until ackN/errN)
//   ackN / errN            : 1-cycle completion / abort pulses
//   grant                  : one-hot requester in service, 0 when idle
//   busy                   : scheduler not idle
//   eng                    : engine handshake (master side)
// Build option: AMP_CFG_PAGE_CACHE_EN keeps the last written page and skips
// redundant page-select writes; without it every request writes the page.
module amp_cfg_sched
  import amp_cfg_pkg::*;
#(
  parameter int unsigned      RETRY_MAX = 3,
  parameter int unsigned      TIMEOUT   = 4095,
  parameter logic [REG_W-1:0] PAGE_REG  = PAGE_REG_DEF
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              req0,
  input  logic [PAGE_W-1:0] page0,
  input  logic [REG_W-1:0]  reg0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  output logic              err0,
  input  logic              req1,
  input  logic [PAGE_W-1:0] page1,
  input  logic [REG_W-1:0]  reg1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              err1,
  output logic [1:0]        grant,
  output logic              busy,
  amp_cfg_sched_if.master   eng
);

  state_e             state_q, state_d;
  wr_req_t            req_q, req_d;
  logic               id_q, id_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [TMO_W-1:0]   tcnt_q, tcnt_d;
  logic [1:0]         grant_d, ack_d, err_d;
  logic               start_d;
  logic [REG_W-1:0]   ereg_d;
  logic [DATA_W-1:0]  edata_d;
  logic [1:0]         req_vec_c, arb_gnt_c;
  logic               adv_c, pg_c, cache_hit_c;

  // A requester whose ack/err is on the wire may still hold req this cycle;
  // mask it so a finished request is not serviced twice.
  assign req_vec_c = {req1, req0} & ~{ack1 | err1, ack0 | err0};
  assign adv_c     = (state_q == ST_RESP) || (state_q == ST_ABORT);
  assign pg_c      = (state_q == ST_PG_WAIT);

  amp_cfg_rr_arb u_arb (
    .clk_in  (clk_in),
    .reset   (reset),
    .req     (req_vec_c),
    .advance (adv_c),
    .served  (id_q),
    .gnt_c   (arb_gnt_c)
  );

`ifdef AMP_CFG_PAGE_CACHE_EN
  logic              cache_vld_q;
  logic [PAGE_W-1:0] cache_page_q;

  // Page cache: set on an ACKed page write, dropped on abort
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cache_vld_q  <= 1'b0;
      cache_page_q <= '0;
    end else if (state_q == ST_ABORT) begin
      cache_vld_q  <= 1'b0;
    end else if (pg_c && eng.eng_done && !eng.eng_nack) begin
      cache_vld_q  <= 1'b1;
      cache_page_q <= req_q.page;
    end
  end

  assign cache_hit_c = cache_vld_q && (cache_page_q == req_q.page);
`else
  assign cache_hit_c = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      id_q          <= 1'b0;
      retry_q       <= '0;
      tcnt_q        <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      ack0          <= 1'b0;
      ack1          <= 1'b0;
      err0          <= 1'b0;
      err1          <= 1'b0;
      eng.eng_start <= 1'b0;
      eng.eng_reg   <= '0;
      eng.eng_data  <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      id_q          <= id_d;
      retry_q       <= retry_d;
      tcnt_q        <= tcnt_d;
      grant         <= grant_d;
      busy          <= (state_d != ST_IDLE);
      ack0          <= ack_d[0];
      ack1          <= ack_d[1];
      err0          <= err_d[0];
      err1          <= err_d[1];
      eng.eng_start <= start_d;
      eng.eng_reg   <= ereg_d;
      eng.eng_data  <= edata_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    retry_d = retry_q;
    tcnt_d  = tcnt_q;
    grant_d = grant;
    ack_d   = '0;
    err_d   = '0;
    start_d = 1'b0;
    ereg_d  = '0;
    edata_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_vec_c) begin
          id_d    = arb_gnt_c[1];
          req_d   = arb_gnt_c[1] ? wr_req_t'{page: page1, addr: reg1, data: data1}
                                 : wr_req_t'{page: page0, addr: reg0, data: data0};
          grant_d = arb_gnt_c;
          retry_d = '0;
          state_d = ST_TAKE;
        end
      end
      ST_TAKE: state_d = cache_hit_c ? ST_DT_ISSUE : ST_PG_ISSUE;
      ST_PG_ISSUE, ST_DT_ISSUE: begin
        if (!eng.eng_busy) begin
          start_d = 1'b1;
          tcnt_d  = '0;
          if (state_q == ST_PG_ISSUE) begin
            ereg_d  = PAGE_REG;
            edata_d = DATA_W'(req_q.page);
            state_d = ST_PG_WAIT;
          end else begin
            ereg_d  = req_q.addr;
            edata_d = req_q.data;
            state_d = ST_DT_WAIT;
          end
        end
      end
      ST_PG_WAIT, ST_DT_WAIT: begin
        if (eng.eng_done) begin
          if (!eng.eng_nack) begin
            state_d = pg_c ? ST_DT_ISSUE : ST_RESP;
          end else if (retry_q < RETRY_W'(RETRY_MAX)) begin
            // one retry budget covers both the page and data write
            retry_d = retry_q + RETRY_W'(1);
            state_d = pg_c ? ST_PG_ISSUE : ST_DT_ISSUE;
          end else begin
            state_d = ST_ABORT;
          end
        end else if (tcnt_q == TMO_W'(TIMEOUT)) begin
          state_d = ST_ABORT;
        end else begin
          tcnt_d = tcnt_q + TMO_W'(1);
        end
      end
      ST_RESP: begin
        ack_d[id_q] = 1'b1;
        grant_d     = '0;
        state_d     = ST_IDLE;
      end
      ST_ABORT: begin
        err_d[id_q] = 1'b1;
        grant_d     = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
